// File: rtl/pwm_ramp_ctrl.sv
// Boot sequencer and rate-limited duty ramp in front of PWM_Top (pclk domain).
// Optional build macro PWM_RAMP_UPDOWN_EN: unit steps reported on up/down pulses.
module pwm_ramp_ctrl #(
   parameter int unsigned W         = 10,
   parameter int unsigned PERIOD    = 1000,
   parameter int unsigned INIT_DUTY = 0,
   parameter int unsigned STEP      = 10,
   parameter int unsigned RAMP_DIV  = 4,
   parameter int unsigned BOOT_WAIT = 8
) (
   input  logic         pclk,
   input  logic         resetn,
   input  logic         enable,
   input  logic [W-1:0] tgt_duty,
   input  logic         tgt_valid,
   output logic         tgt_ready,
   output logic         pwm_en,
   output logic [W-1:0] initial_cycle,
   output logic [W-1:0] initial_duty_cycle,
   output logic         initial_update,
   output logic [W-1:0] duty_cycle,
   output logic         duty_cycle_update,
   output logic         up,
   output logic         down,
   output logic         busy
);

   localparam int unsigned INIT_CLAMP = (INIT_DUTY > PERIOD) ? PERIOD : INIT_DUTY;
   localparam int unsigned STEP_CLAMP = (STEP > PERIOD) ? PERIOD : STEP;
   localparam int unsigned BCW        = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
   localparam int unsigned PCW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [W-1:0] PERIOD_W  = W'(PERIOD);
   localparam logic [W-1:0] INIT_W    = W'(INIT_CLAMP);

   typedef enum logic [1:0] {S_BOOT, S_INIT, S_HOLD, S_RAMP} state_t;

   state_t         state, state_n;
   logic [BCW-1:0] boot_cnt, boot_cnt_n;
   logic [PCW-1:0] presc, presc_n;
   logic [W-1:0]   tgt, tgt_n;
   logic [W-1:0]   duty_n;
   logic           upd_n, up_n, down_n;
   logic           ready_n, busy_n, pwm_en_n, init_upd_n;

   logic           accept_c, dir_up_c;
   logic [W-1:0]   tgt_clamp_c, diff_c, step_c, stepped_c;

   assign initial_cycle      = PERIOD_W;
   assign initial_duty_cycle = INIT_W;

   // Clamp incoming target and compute the next bounded step toward the live target
   assign accept_c    = tgt_valid & tgt_ready;
   assign tgt_clamp_c = (tgt_duty > PERIOD_W) ? PERIOD_W : tgt_duty;
   assign dir_up_c    = (tgt > duty_cycle);
   assign diff_c      = dir_up_c ? (tgt - duty_cycle) : (duty_cycle - tgt);
`ifdef PWM_RAMP_UPDOWN_EN
   assign step_c      = W'(1);
`else
   assign step_c      = (diff_c < W'(STEP_CLAMP)) ? diff_c : W'(STEP_CLAMP);
`endif
   assign stepped_c   = dir_up_c ? (duty_cycle + step_c) : (duty_cycle - step_c);

   // Next-state, datapath and output decode
   always_comb begin
      state_n    = state;
      boot_cnt_n = boot_cnt;
      presc_n    = presc;
      tgt_n      = tgt;
      duty_n     = duty_cycle;
      upd_n      = 1'b0;
      up_n       = 1'b0;
      down_n     = 1'b0;
      case (state)
         S_BOOT: begin
            if (boot_cnt == BCW'(BOOT_WAIT - 1)) state_n = S_INIT;
            else                                 boot_cnt_n = boot_cnt + BCW'(1);
         end
         S_INIT: state_n = S_HOLD;
         S_HOLD: begin
            if (accept_c) begin
               tgt_n   = tgt_clamp_c;
               presc_n = '0;
               if (tgt_clamp_c != duty_cycle) state_n = S_RAMP;
            end
         end
         S_RAMP: begin
            if (accept_c) begin
               // a new target restarts the tick interval
               tgt_n   = tgt_clamp_c;
               presc_n = '0;
               if (tgt_clamp_c == duty_cycle) state_n = S_HOLD;
            end else if (enable) begin
               if (presc == PCW'(RAMP_DIV - 1)) begin
                  presc_n = '0;
                  duty_n  = stepped_c;
`ifdef PWM_RAMP_UPDOWN_EN
                  up_n    = dir_up_c;
                  down_n  = ~dir_up_c;
`else
                  upd_n   = 1'b1;
`endif
                  if (stepped_c == tgt) state_n = S_HOLD;
               end else begin
                  presc_n = presc + PCW'(1);
               end
            end
         end
         default: state_n = S_BOOT;
      endcase
      init_upd_n = (state_n == S_INIT);
      ready_n    = (state_n == S_HOLD) || (state_n == S_RAMP);
      busy_n     = (state_n != S_HOLD);
      pwm_en_n   = enable & ready_n;
   end

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         state             <= S_BOOT;
         boot_cnt          <= '0;
         presc             <= '0;
         tgt               <= INIT_W;
         duty_cycle        <= INIT_W;
         duty_cycle_update <= 1'b0;
         up                <= 1'b0;
         down              <= 1'b0;
         initial_update    <= 1'b0;
         tgt_ready         <= 1'b0;
         busy              <= 1'b1;
         pwm_en            <= 1'b0;
      end else begin
         state             <= state_n;
         boot_cnt          <= boot_cnt_n;
         presc             <= presc_n;
         tgt               <= tgt_n;
         duty_cycle        <= duty_n;
         duty_cycle_update <= upd_n;
         up                <= up_n;
         down              <= down_n;
         initial_update    <= init_upd_n;
         tgt_ready         <= ready_n;
         busy              <= busy_n;
         pwm_en            <= pwm_en_n;
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl against a cycle-level arithmetic reference model.
module tb_pwm_ramp_ctrl;

   localparam int unsigned W         = 10;
   localparam int unsigned PERIOD    = 1000;
   localparam int unsigned INIT_DUTY = 0;
   localparam int unsigned STEP      = 10;
   localparam int unsigned RAMP_DIV  = 4;
   localparam int unsigned BOOT_WAIT = 8;
   localparam int unsigned VW        = W + 7;
`ifdef PWM_RAMP_UPDOWN_EN
   localparam int STEP_EFF = 1;
`else
   localparam int STEP_EFF = int'(STEP);
`endif

   logic         pclk, resetn, enable, tgt_valid;
   logic [W-1:0] tgt_duty;
   logic         tgt_ready, pwm_en, initial_update, duty_cycle_update, up, down, busy;
   logic [W-1:0] initial_cycle, initial_duty_cycle, duty_cycle;

   int checks, errors;

   // reference model state
   int m_duty, m_tgt, m_elapsed, n_edges;
   bit m_ramp, m_upd, m_up, m_down, m_pwm;

   pwm_ramp_ctrl #(
      .W(W), .PERIOD(PERIOD), .INIT_DUTY(INIT_DUTY), .STEP(STEP),
      .RAMP_DIV(RAMP_DIV), .BOOT_WAIT(BOOT_WAIT)
   ) dut (
      .pclk(pclk), .resetn(resetn), .enable(enable),
      .tgt_duty(tgt_duty), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
      .pwm_en(pwm_en), .initial_cycle(initial_cycle),
      .initial_duty_cycle(initial_duty_cycle), .initial_update(initial_update),
      .duty_cycle(duty_cycle), .duty_cycle_update(duty_cycle_update),
      .up(up), .down(down), .busy(busy)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic void model_reset();
      m_duty = int'(INIT_DUTY);
      m_tgt = m_duty; m_elapsed = 0; n_edges = 0;
      m_ramp = 0; m_upd = 0; m_up = 0; m_down = 0; m_pwm = 0;
   endfunction

   // One clock edge of the reference: boot takes BOOT_WAIT edges, load pulse on the next,
   // then targets are accepted and the duty moves min(step, distance) every RAMP_DIV enabled cycles.
   function automatic void model_edge();
      int c, d, mag, s;
      bit ready;
      if (!resetn) return;
      ready = (n_edges >= int'(BOOT_WAIT) + 1);
      m_upd = 0; m_up = 0; m_down = 0;
      if (ready && tgt_valid) begin
         c = (int'(tgt_duty) > int'(PERIOD)) ? int'(PERIOD) : int'(tgt_duty);
         m_tgt = c;
         m_elapsed = 0;
         m_ramp = (c != m_duty);
      end else if (m_ramp && enable) begin
         m_elapsed++;
         if (m_elapsed == int'(RAMP_DIV)) begin
            m_elapsed = 0;
            d = m_tgt - m_duty;
            mag = (d < 0) ? -d : d;
            s = (mag < STEP_EFF) ? mag : STEP_EFF;
            m_duty = (d > 0) ? m_duty + s : m_duty - s;
`ifdef PWM_RAMP_UPDOWN_EN
            m_up = (d > 0); m_down = (d < 0);
`else
            m_upd = 1;
`endif
            if (m_duty == m_tgt) m_ramp = 0;
         end
      end
      n_edges++;
      m_pwm = enable && (n_edges >= int'(BOOT_WAIT) + 1);
   endfunction

   function automatic logic [VW-1:0] model_vec();
      bit booted;
      booted = (n_edges >= int'(BOOT_WAIT) + 1);
      return {W'(m_duty), m_upd, m_up, m_down, (!booted || m_ramp), m_pwm, booted,
              (n_edges == int'(BOOT_WAIT))};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {duty_cycle, duty_cycle_update, up, down, busy, pwm_en, tgt_ready, initial_update};
   endfunction

   task automatic clk_step();
      @(posedge pclk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      resetn = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      model_reset();
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), model_vec());
      end
      checks++;
      if (initial_cycle !== W'(PERIOD) || initial_duty_cycle !== W'(INIT_DUTY)) begin
         errors++; $display("FAIL boot_consts got %0d/%0d exp %0d/%0d",
                            initial_cycle, initial_duty_cycle, PERIOD, INIT_DUTY);
      end
      resetn = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         clk_step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL boot cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_ramp_up();
      int pulses = 0;
      tgt_duty = W'(100); tgt_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         clk_step();
         tgt_valid = 1'b0;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL ramp_up cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
         if (duty_cycle_update || up || down) pulses++;
         if (!m_ramp) break;
      end
      checks++;
      if (pulses != (100 + STEP_EFF - 1) / STEP_EFF || duty_cycle !== W'(100) || busy !== 1'b0) begin
         errors++; $display("FAIL ramp_up_end pulses %0d duty %0d busy %b exp %0d/100/0",
                            pulses, duty_cycle, busy, (100 + STEP_EFF - 1) / STEP_EFF);
      end
   endtask

   task automatic test_same_target();
      int pulses = 0;
      for (int rep = 0; rep < 2; rep++) begin
         tgt_duty = W'(95); tgt_valid = 1'b1;
         for (int i = 0; i < 30; i++) begin
            clk_step();
            tgt_valid = 1'b0;
            checks++;
            if (dut_vec() !== model_vec()) begin
               errors++; $display("FAIL same_tgt rep %0d cyc %0d got %h exp %h",
                                  rep, i, dut_vec(), model_vec());
            end
            if (rep == 1 && (duty_cycle_update || up || down || busy)) pulses++;
            if (!m_ramp && i >= 6) break;
         end
      end
      checks++;
      if (pulses != 0 || duty_cycle !== W'(95)) begin
         errors++; $display("FAIL same_tgt_end repeat_activity %0d duty %0d exp 0/95", pulses, duty_cycle);
      end
   endtask

   task automatic test_clamp();
      tgt_duty = W'(1023); tgt_valid = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         clk_step();
         tgt_valid = 1'b0;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL clamp cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
         if (!m_ramp) break;
      end
      checks++;
      if (duty_cycle !== W'(PERIOD) || busy !== 1'b0) begin
         errors++; $display("FAIL clamp_end duty %0d busy %b exp %0d/0", duty_cycle, busy, PERIOD);
      end
   endtask

   task automatic test_reverse();
      tgt_duty = W'(940); tgt_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         clk_step();
         tgt_valid = 1'b0;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reverse_a cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
      end
      tgt_duty = W'(995); tgt_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         clk_step();
         tgt_valid = 1'b0;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reverse_b cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
         if (!m_ramp) break;
      end
      checks++;
      if (duty_cycle !== W'(995)) begin
         errors++; $display("FAIL reverse_end duty %0d exp 995", duty_cycle);
      end
   endtask

   task automatic test_enable();
      tgt_duty = W'(900); tgt_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         clk_step();
         tgt_valid = 1'b0;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL enable_run cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
      end
      enable = 1'b0;
      #1;
      checks++;
      if (pwm_en !== 1'b1) begin
         errors++; $display("FAIL pwm_en_latency got %b exp 1", pwm_en);
      end
      for (int i = 0; i < 12; i++) begin
         clk_step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL enable_frozen cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
      end
      enable = 1'b1;
      for (int i = 0; i < 500; i++) begin
         clk_step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL enable_resume cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
         if (!m_ramp) break;
      end
      checks++;
      if (duty_cycle !== W'(900)) begin
         errors++; $display("FAIL enable_end duty %0d exp 900", duty_cycle);
      end
   endtask

   task automatic test_reset_mid();
      tgt_duty = W'(0); tgt_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         clk_step();
         tgt_valid = 1'b0;
      end
      resetn = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++; $display("FAIL reset_mid got %h exp %h", dut_vec(), model_vec());
      end
      repeat (3) clk_step();
      resetn = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         clk_step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reboot cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) enable = ~enable;
         tgt_valid = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 2) == 0) tgt_duty = W'(m_duty + int'($urandom_range(0, 30)));
         else                           tgt_duty = W'($urandom_range(0, 1023));
         clk_step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL random cyc %0d got %h exp %h", i, dut_vec(), model_vec());
         end
      end
      tgt_valid = 1'b0;
      enable = 1'b1;
   endtask

   initial begin
      checks = 0; errors = 0;
      resetn = 1'b0; enable = 1'b0; tgt_valid = 1'b0; tgt_duty = '0;
      model_reset();
      test_reset();
      test_ramp_up();
      test_same_target();
      test_clamp();
      test_reverse();
      test_enable();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
